// File: rtl/burst_ram_wrap.sv
// Burst-oriented external RAM model: byte-masked write bursts, linear or
// wrap (critical-word-first) read/write bursts, periodic refresh stalls and
// a one-cycle pulse for every command that could not be taken.
module burst_ram_wrap #(
  parameter string DATA_FILE                = "",
  parameter int    DEPTH_BITWIDTH           = 4,
  parameter int    DATA_BITWIDTH            = 64,
  parameter int    BURST_COUNT              = 4,
  parameter int    CYCLES_BEFORE_INITIATED  = 10,
  parameter int    CYCLES_BEFORE_DATA_VALID = 4,
  parameter int    REFRESH_INTERVAL         = 64,
  parameter int    REFRESH_CYCLES           = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd,
  input  logic                         cmd_en,
  input  logic                         burst_wrap,
  input  logic [DEPTH_BITWIDTH-1:0]    addr,
  input  logic [DATA_BITWIDTH-1:0]     wr_data,
  input  logic [DATA_BITWIDTH/8-1:0]   data_mask,
  output logic [DATA_BITWIDTH-1:0]     rd_data,
  output logic                         rd_data_valid,
  output logic                         busy,
  output logic                         cmd_dropped
);

  localparam int AW      = DEPTH_BITWIDTH;
  localparam int DW      = DATA_BITWIDTH;
  localparam int NB      = DATA_BITWIDTH / 8;
  localparam int DEPTH   = 1 << DEPTH_BITWIDTH;
  localparam int IDX_W   = $clog2(BURST_COUNT) + 1;
  localparam int CNT_MAX = (CYCLES_BEFORE_INITIATED > CYCLES_BEFORE_DATA_VALID)
                         ? ((CYCLES_BEFORE_INITIATED > REFRESH_CYCLES) ? CYCLES_BEFORE_INITIATED : REFRESH_CYCLES)
                         : ((CYCLES_BEFORE_DATA_VALID > REFRESH_CYCLES) ? CYCLES_BEFORE_DATA_VALID : REFRESH_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;
  localparam int REF_W   = $clog2(REFRESH_INTERVAL + 1) + 1;

  localparam logic [AW-1:0]    BURST_MASK = AW'(BURST_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BURST_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(BURST_COUNT);
  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(CYCLES_BEFORE_INITIATED - 1);
  localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(CYCLES_BEFORE_DATA_VALID);
  localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [REF_W-1:0] INTV_LAST  = REF_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_IDLE       = 3'd1,
    ST_WRITE      = 3'd2,
    ST_READ_WAIT  = 3'd3,
    ST_READ_BURST = 3'd4,
    ST_REFRESH    = 3'd5
  } state_e;

  // Word address of burst beat idx; wrap mode stays inside the aligned block.
  function automatic logic [AW-1:0] burst_addr(input logic [AW-1:0] base,
                                               input logic wrap,
                                               input logic [IDX_W-1:0] idx);
    logic [AW-1:0] lin;
    lin = base + AW'(idx);
    if (wrap) burst_addr = (base & ~BURST_MASK) | (lin & BURST_MASK);
    else      burst_addr = lin;
  endfunction

  // Byte merge: a set mask bit keeps the old byte.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [NB-1:0] mask);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (!mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  logic [DW-1:0]    mem_q [DEPTH];
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             wrap_q, wrap_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             dropped_q, dropped_d;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             ref_pend_q, ref_pend_d;
  logic             accept_s, ref_clr_s, mem_we_s;
  logic [AW-1:0]    mem_waddr_s;
  logic [DW-1:0]    mem_wdata_s;
  logic [NB-1:0]    mem_wmask_s;

  // Preload memory contents at elaboration (zero).
  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

  // Next-state, burst sequencing and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wrap_d      = wrap_q;
    rd_data_d   = rd_data_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    accept_s    = 1'b0;
    ref_clr_s   = 1'b0;
    mem_we_s    = 1'b0;
    mem_waddr_s = addr;
    mem_wdata_s = wr_data;
    mem_wmask_s = data_mask;
    case (state_q)
      ST_INIT: begin
        busy_d = 1'b1;
        if (cnt_q == INIT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        if (ref_pend_q) begin
          // Refresh wins over a same-cycle command.
          state_d   = ST_REFRESH;
          cnt_d     = '0;
          busy_d    = 1'b1;
          ref_clr_s = 1'b1;
        end else if (cmd_en) begin
          accept_s = 1'b1;
          addr_d   = addr;
          wrap_d   = burst_wrap;
          idx_d    = IDX_W'(1);
          cnt_d    = '0;
          busy_d   = 1'b1;
          if (cmd) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = burst_addr(addr, burst_wrap, IDX_W'(0));
            state_d     = ST_WRITE;
          end else begin
            state_d = ST_READ_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = burst_addr(addr_q, wrap_q, idx_q);
        idx_d       = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_READ_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d   = ST_READ_BURST;
          rd_data_d = mem_q[burst_addr(addr_q, wrap_q, IDX_W'(0))];
          valid_d   = 1'b1;
          idx_d     = IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READ_BURST: begin
        if (idx_q == IDX_END) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          rd_data_d = mem_q[burst_addr(addr_q, wrap_q, idx_q)];
          idx_d     = idx_q + IDX_W'(1);
        end
      end
      ST_REFRESH: begin
        if (cnt_q == REF_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b1;
      end
    endcase
    // Write-burst data edges carry don't-care command strobes.
    dropped_d = cmd_en & ~accept_s & (state_q != ST_WRITE);
  end

  // Free-running refresh interval counter; one pending request at most.
  always_comb begin
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    if (REFRESH_INTERVAL == 0) begin
      ref_cnt_d  = '0;
      ref_pend_d = 1'b0;
    end else if (state_q == ST_INIT) begin
      ref_cnt_d  = '0;
      ref_pend_d = 1'b0;
    end else if (ref_cnt_q == INTV_LAST) begin
      ref_cnt_d  = '0;
      ref_pend_d = 1'b1;
    end else begin
      ref_cnt_d  = ref_cnt_q + REF_W'(1);
      ref_pend_d = ref_pend_q & ~ref_clr_s;
    end
  end

  // Control state and registered outputs; memory is not touched by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      wrap_q     <= 1'b0;
      rd_data_q  <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b1;
      dropped_q  <= 1'b0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wrap_q     <= wrap_d;
      rd_data_q  <= rd_data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      dropped_q  <= dropped_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
    end
  end

  // Byte-masked memory write port.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_q[mem_waddr_s] <= merge_bytes(mem_q[mem_waddr_s], mem_wdata_s, mem_wmask_s);
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = valid_q;
  assign busy          = busy_q;
  assign cmd_dropped   = dropped_q;

endmodule
